// File: rtl/adder_subtractor_pkg.sv
// Shared definitions for the adder_subtractor BIST engine and its golden model.
package adder_subtractor_pkg;

   localparam int WIDTH_DEF = 4;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } bist_state_t;

endpackage

// File: rtl/adder_subtractor_model.sv
// Combinational golden model of the adder_subtractor: add, or two's-complement subtract
// where carry = 1 means no borrow.
module adder_subtractor_model
   import adder_subtractor_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [WIDTH-1:0] A_i,
   input  logic [WIDTH-1:0] B_i,
   input  logic             mode_i,
   output logic [WIDTH-1:0] exp_result_o,
   output logic             exp_carry_o
);

   logic [WIDTH:0] sum;

   // Subtract is A + ~B + 1 so the carry-out doubles as the "no borrow" flag.
   always_comb begin
      if (mode_i == MODE_SUB) begin
         sum = {1'b0, A_i} + {1'b0, ~B_i} + (WIDTH+1)'(1);
      end else begin
         sum = {1'b0, A_i} + {1'b0, B_i};
      end
   end

   assign exp_result_o = sum[WIDTH-1:0];
   assign exp_carry_o  = sum[WIDTH];

endmodule

// File: rtl/adder_subtractor_bist.sv
// Built-in self-test engine: sweeps every {mode, A, B} vector through an external
// adder_subtractor, compares against the golden model and reports the outcome.
module adder_subtractor_bist
   import adder_subtractor_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic [WIDTH-1:0]   A,
   output logic [WIDTH-1:0]   B,
   output logic               mode,
   input  logic [WIDTH-1:0]   result,
   input  logic               carry,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [2*WIDTH+1:0] fail_count,
   output logic [WIDTH-1:0]   first_fail_A,
   output logic [WIDTH-1:0]   first_fail_B,
   output logic               first_fail_mode
);

   localparam int IDX_W = 2*WIDTH + 1;
   localparam int FC_W  = 2*WIDTH + 2;
   localparam logic [IDX_W-1:0] IDX_LAST = '1;

   bist_state_t       state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [FC_W-1:0]   fail_count_q, fail_count_d;
   logic              pass_q, pass_d;
   logic [WIDTH-1:0]  ff_A_q, ff_A_d;
   logic [WIDTH-1:0]  ff_B_q, ff_B_d;
   logic              ff_mode_q, ff_mode_d;

   logic [WIDTH-1:0]  exp_result;
   logic              exp_carry;
   logic              mismatch;

   // The index register drives the operands directly, so they hold the last vector
   // after the sweep and only return to 0 on reset.
   assign mode = idx_q[2*WIDTH];
   assign A    = idx_q[2*WIDTH-1:WIDTH];
   assign B    = idx_q[WIDTH-1:0];

   adder_subtractor_model #(.WIDTH(WIDTH)) u_model (
      .A_i          (A),
      .B_i          (B),
      .mode_i       (mode),
      .exp_result_o (exp_result),
      .exp_carry_o  (exp_carry)
   );

   assign mismatch = ({carry, result} != {exp_carry, exp_result});

   // Next-state and datapath update for the IDLE -> DRIVE -> CHECK ... -> DONE sweep.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      fail_count_d = fail_count_q;
      pass_d       = pass_q;
      ff_A_d       = ff_A_q;
      ff_B_d       = ff_B_q;
      ff_mode_d    = ff_mode_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               idx_d        = '0;
               fail_count_d = '0;
               pass_d       = 1'b0;
               ff_A_d       = '0;
               ff_B_d       = '0;
               ff_mode_d    = 1'b0;
               state_d      = DRIVE;
            end
         end
         DRIVE: begin
            // One full cycle for the operands to settle through the unit under test.
            state_d = CHECK;
         end
         CHECK: begin
            if (mismatch) begin
               fail_count_d = fail_count_q + FC_W'(1);
               if (fail_count_q == '0) begin
                  ff_A_d    = A;
                  ff_B_d    = B;
                  ff_mode_d = mode;
               end
            end
            if (idx_q == IDX_LAST) begin
               // Verdict is ready in the same cycle that done pulses.
               pass_d  = (fail_count_d == '0);
               state_d = DONE;
            end else begin
               idx_d   = idx_q + IDX_W'(1);
               state_d = DRIVE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and result registers; reset aborts any sweep and zeroes every output.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         fail_count_q <= '0;
         pass_q       <= 1'b0;
         ff_A_q       <= '0;
         ff_B_q       <= '0;
         ff_mode_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         fail_count_q <= fail_count_d;
         pass_q       <= pass_d;
         ff_A_q       <= ff_A_d;
         ff_B_q       <= ff_B_d;
         ff_mode_q    <= ff_mode_d;
      end
   end

   assign busy            = (state_q == DRIVE) || (state_q == CHECK);
   assign done            = (state_q == DONE);
   assign pass            = pass_q;
   assign fail_count      = fail_count_q;
   assign first_fail_A    = ff_A_q;
   assign first_fail_B    = ff_B_q;
   assign first_fail_mode = ff_mode_q;

endmodule

// File: tb/tb_adder_subtractor_bist.sv
// Bench for adder_subtractor_bist: a behavioural adder_subtractor with selectable
// faults sits on the other side of the interface; each sweep's expected outcome is
// queued at start and compared when done appears.
module tb_adder_subtractor_bist;

   localparam int W   = 4;
   localparam int N   = 512;
   localparam int FCW = 2*W + 2;

   logic           clk = 1'b0;
   logic           rst;
   logic           start;
   logic [W-1:0]   A, B, result;
   logic           mode, carry;
   logic           busy, done, pass;
   logic [FCW-1:0] fail_count;
   logic [W-1:0]   ff_A, ff_B;
   logic           ff_mode;
   int             fault;
   logic [W:0]     ref_s;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      int             fault;
      logic [FCW-1:0] fc;
      logic           ps;
      logic [W-1:0]   fa;
      logic [W-1:0]   fb;
      logic           fm;
   } vec_t;

   vec_t tbl[4];
   vec_t exp_q[$];

   always #5 clk = ~clk;

   adder_subtractor_bist #(.WIDTH(W)) dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .A               (A),
      .B               (B),
      .mode            (mode),
      .result          (result),
      .carry           (carry),
      .busy            (busy),
      .done            (done),
      .pass            (pass),
      .fail_count      (fail_count),
      .first_fail_A    (ff_A),
      .first_fail_B    (ff_B),
      .first_fail_mode (ff_mode)
   );

   // Unit under test: correct adder_subtractor plus optional planted faults.
   always_comb begin
      ref_s  = mode ? ({1'b0, A} + {1'b0, ~B} + 5'd1) : ({1'b0, A} + {1'b0, B});
      result = ref_s[W-1:0];
      carry  = ref_s[W];
      case (fault)
         1: result[0] = 1'b0;
         2: carry = ~carry;
         3: if (mode) carry = ~carry;
         default: ;
      endcase
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_AB_mode"}, {23'd0, mode, A, B}, 32'd0);
      check({tag, "_busy_done_pass"}, {29'd0, busy, done, pass}, 32'd0);
      check({tag, "_fail_count"}, {22'd0, fail_count}, 32'd0);
      check({tag, "_first_fail"}, {23'd0, ff_mode, ff_A, ff_B}, 32'd0);
   endtask

   task automatic run_sweep(input vec_t v, input bit repulse);
      int   edge_n;
      int   busy_cnt;
      int   order_bad;
      int   i;
      bit   got_done;
      vec_t e;
      fault = v.fault;
      exp_q.push_back(v);
      check("idle_before_start", {31'd0, busy}, 32'd0);
      start = 1'b1;
      @(posedge clk); #1;
      start     = 1'b0;
      edge_n    = 0;
      busy_cnt  = busy ? 1 : 0;
      order_bad = 0;
      got_done  = 1'b0;
      while (!got_done && edge_n < 2*N + 20) begin
         start = (repulse && (edge_n == 9 || edge_n == 499)) ? 1'b1 : 1'b0;
         @(posedge clk); #1;
         edge_n++;
         if ((edge_n % 2 == 1) && edge_n < 2*N) begin
            i = (edge_n - 1) / 2;
            if ({mode, A, B} !== 9'(i)) order_bad++;
         end
         if (done) got_done = 1'b1;
         else if (busy) busy_cnt++;
      end
      start = 1'b0;
      check("done_edge", edge_n, 2*N);
      check("busy_cycles", busy_cnt, 2*N);
      check("busy_at_done", {31'd0, busy}, 32'd0);
      check("vector_order_errors", order_bad, 0);
      e = exp_q.pop_front();
      check("fail_count", {22'd0, fail_count}, {22'd0, e.fc});
      check("pass", {31'd0, pass}, {31'd0, e.ps});
      check("first_fail_A", {28'd0, ff_A}, {28'd0, e.fa});
      check("first_fail_B", {28'd0, ff_B}, {28'd0, e.fb});
      check("first_fail_mode", {31'd0, ff_mode}, {31'd0, e.fm});
      @(posedge clk); #1;
      check("done_one_cycle", {31'd0, done}, 32'd0);
      check("pass_held", {31'd0, pass}, {31'd0, e.ps});
      check("vector_held", {23'd0, mode, A, B}, 32'h1FF);
   endtask

   initial begin
      int exp_part;
      logic [8:0] j9;
      rst   = 1'b1;
      start = 1'b0;
      fault = 0;

      //           fault  fc         pass  A     B     mode
      tbl[0] = '{0, 10'd0,   1'b1, 4'd0, 4'd0, 1'b0};
      tbl[1] = '{1, 10'd256, 1'b0, 4'd0, 4'd1, 1'b0};
      tbl[2] = '{2, 10'd512, 1'b0, 4'd0, 4'd0, 1'b0};
      tbl[3] = '{3, 10'd256, 1'b0, 4'd0, 4'd0, 1'b1};

      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b0;
      @(posedge clk); #1;
      check_all_zero("idle");

      for (int k = 0; k < 4; k++) run_sweep(tbl[k], 1'b0);

      // Reset in the middle of a faulty sweep, applied at edge 300.
      fault = 1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (299) @(posedge clk);
      #1;
      exp_part = 0;
      for (int jj = 0; jj < 149; jj++) begin
         j9 = 9'(jj);
         if (j9[4] ^ j9[0]) exp_part++;
      end
      check("partial_fail_count", {22'd0, fail_count}, exp_part);
      check("busy_mid_sweep", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      check_all_zero("mid_reset");
      rst = 1'b0;
      @(posedge clk); #1;
      check_all_zero("after_mid_reset");
      run_sweep(tbl[0], 1'b0);

      // start re-pulsed at edges 10 and 500 while busy must not disturb the sweep.
      run_sweep(tbl[1], 1'b1);
      @(posedge clk); #1;
      check("no_relaunch", {31'd0, busy}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/adder_subtractor_bist.md
Name: adder_subtractor_bist

Overview:
- Synthesizable built-in self-test engine that drives the other side of the adder_subtractor interface.
- It generates operands A, B and mode, samples result and carry back, and compares them against an internal golden model.
- It sweeps every input combination exhaustively and reports pass/fail, a failure count and the first failing vector.
- It sits beside the combinational adder_subtractor and is started by a top-level test controller.

Parameters:
WIDTH, 4, operand width of the adder_subtractor under test.

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  begin sweep; sampled only in IDLE
A  output  WIDTH  operand A driven to adder_subtractor
B  output  WIDTH  operand B driven to adder_subtractor
mode  output  1  0 = add, 1 = subtract
result  input  WIDTH  sum/difference returned by adder_subtractor
carry  input  1  carry-out returned by adder_subtractor
busy  output  1  high from the start edge until done
done  output  1  one-cycle pulse at end of sweep
pass  output  1  level; valid after done, held until next start
fail_count  output  2*WIDTH+2  number of mismatching vectors
first_fail_A  output  WIDTH  A of first mismatch
first_fail_B  output  WIDTH  B of first mismatch
first_fail_mode  output  1  mode of first mismatch

Behaviour:
- Reset: state IDLE; every output is 0, including A, B, mode, busy, done, pass, fail_count and the first_fail_* outputs.
- Reset mid-sweep aborts immediately with the same values. There is no resume.
- Vector index idx has width 2*WIDTH+1, so N = 2^(2*WIDTH+1) vectors (512 at WIDTH=4).
- Index mapping: mode = idx[2W], A = idx[2W-1:W], B = idx[W-1:0].
  - Order runs from mode0/A0/B0 to mode1/A15/B15.
- Golden model:
  - Add: {carry, result} = A + B.
  - Subtract: {carry, result} = A + ~B + 1, two's complement. carry = 1 means no borrow (A >= B).
- FSM states: IDLE, DRIVE, CHECK, DONE.
  - IDLE: when start = 1 at an edge:
    - clear fail_count, pass and the first_fail_* outputs;
    - set idx = 0 and busy = 1;
    - go to DRIVE.
  - DRIVE: A, B and mode reflect idx. Always go to CHECK at the next edge, which gives one full cycle of settling through the combinational block.
  - CHECK: at the edge, compare {carry, result} with the golden value for the current idx.
    - On mismatch, fail_count increments. If fail_count was 0, capture the first_fail_* outputs.
    - If idx == N-1, go to DONE. Otherwise idx increments and the FSM goes to DRIVE.
  - DONE: done = 1 for exactly this cycle; pass = (fail_count == 0); busy = 0; go to IDLE at the next edge.
- Timing: with the start edge as edge 0, vector i is compared at edge 2i+2. done is high in the cycle after edge 2N (edge 1024 at WIDTH=4).
- A, B and mode hold the last vector in DONE and IDLE; they return to 0 only on reset.
- start while busy is ignored. start held high through DONE relaunches a sweep from IDLE on the following edge.
- fail_count cannot overflow, because its maximum value N fits in 2*WIDTH+2 bits.

Decomposition:
- Shared package adder_subtractor_pkg holds:
  - the WIDTH default;
  - MODE_ADD = 0 and MODE_SUB = 1;
  - the FSM state encoding (IDLE, DRIVE, CHECK, DONE).
- The golden model is a natural sub-module: adder_subtractor_model, purely combinational, taking A, B and mode and producing exp_result and exp_carry. It is reusable by benches.

Test Plan:
- Correct adder_subtractor attached; pulse start at edge 0 -> busy high for edges 1..1024, done pulse after edge 1024, pass = 1, fail_count = 0.
- result[0] stuck at 0 -> fail_count = 256, pass = 0, first_fail = mode0 A0 B1.
- carry inverted -> fail_count = 512, first_fail = mode0 A0 B0.
- Subtract with borrow-convention carry (carry = 1 when A < B) -> fail_count = 256, first_fail = mode1 A0 B0.
- rst asserted at edge 300 -> all outputs 0 and state IDLE the next cycle; a new start gives a clean full sweep with pass = 1.
- start re-pulsed at edges 10 and 500 while busy -> ignored; done still after edge 1024 and a single sweep is counted.
